// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Sequential hazard controller for an NSTAGE-deep, ISSUE-wide in-order
//   pipeline. It drives every pipeline register's enable and synchronous
//   flush. Its stall sources are:
//     - load-use, found from an in-flight load tracker
//     - an internally counted divider stall
//     - instruction and data memory stalls
//   An exception that arrives while the pipe is stalled is held pending.
//   The flush stays asserted until the stall releases and the flush can
//   take effect.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   i_stall         instruction memory not ready
//   d_stall         data memory not ready
//   d_src_valid     per D slot {rt,rs} source used      [2*ISSUE]
//   d_src           per D slot {rt,rs} register numbers [10*ISSUE]
//   d_load_valid    D slot holds a load                 [ISSUE]
//   d_load_waddr    load destination per D slot         [5*ISSUE]
//   d_branch_taken  branch resolved taken in D
//   e_div           divide/modulo valid in E
//   except          exception raised in stage NSTAGE-2
//   stage_ena       per-stage enable                    [NSTAGE]
//   stage_flush     per-stage synchronous flush         [NSTAGE]
//   longest_stall   i_stall | d_stall | div_stall
//   lwstall         load-use stall
//   div_stall       divider holding E
//   except_pending  exception held while the pipe is stalled
//
// Exception FSM
//   state | meaning
//   RUN   | no exception outstanding
//   HOLD  | exception seen during a stall, flushes held until release

module hazard_ctrl #(
    parameter int NSTAGE   = 5,
    parameter int ISSUE    = 2,
    parameter int DIV_CYC  = 32,
    localparam int LD_DEPTH = NSTAGE - 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  d_stall,
    input  logic [2*ISSUE-1:0]    d_src_valid,
    input  logic [10*ISSUE-1:0]   d_src,
    input  logic [ISSUE-1:0]      d_load_valid,
    input  logic [5*ISSUE-1:0]    d_load_waddr,
    input  logic                  d_branch_taken,
    input  logic                  e_div,
    input  logic                  except,
    output logic [NSTAGE-1:0]     stage_ena,
    output logic [NSTAGE-1:0]     stage_flush,
    output logic                  longest_stall,
    output logic                  lwstall,
    output logic                  div_stall,
    output logic                  except_pending
);

    localparam int CW = (DIV_CYC > 2) ? $clog2(DIV_CYC) : 1;

    typedef enum logic {RUN, HOLD} state_t;

    state_t state_q, state_d;

    // Tracker slot 0 mirrors E; higher slots follow the load down the M stages.
    logic [LD_DEPTH-1:0][ISSUE-1:0]       trk_valid;
    logic [LD_DEPTH-1:0][ISSUE-1:0][4:0]  trk_waddr;

    logic [CW-1:0] cnt;
    logic          done;
    logic          xflush;
    logic          d_advance;

    // Load-use: any valid D source against any valid in-flight load.
    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        lwstall = 1'b0;
        for (int j = 0; j < 2*ISSUE; j++) begin
            for (int k = 0; k < LD_DEPTH; k++) begin
                for (int i = 0; i < ISSUE; i++) begin
                    if (d_src_valid[j] && (d_src[5*j +: 5] != 5'd0) &&
                        trk_valid[k][i] && (trk_waddr[k][i] == d_src[5*j +: 5]))
                        lwstall = 1'b1;
                end
            end
        end
    end

    assign div_stall      = e_div & ~done;
    assign longest_stall  = i_stall | d_stall | div_stall;
    assign xflush         = except | (state_q == HOLD);
    assign except_pending = (state_q == HOLD);

    assign stage_ena[1:0]        = {2{~(lwstall | longest_stall)}};
    assign stage_ena[NSTAGE-2:2] = {(NSTAGE-3){~longest_stall}};
    // W may retire during a divide only when the divide is being flushed.
    // This lets the excepting instruction leave without waiting for the
    // divider.
    assign stage_ena[NSTAGE-1]   = ~longest_stall | (div_stall & xflush);

    assign stage_flush[0]          = 1'b0;
    assign stage_flush[1]          = xflush | d_branch_taken;
    assign stage_flush[NSTAGE-2:2] = {(NSTAGE-3){xflush}};
    assign stage_flush[NSTAGE-1]   = 1'b0;

    assign d_advance = ~lwstall & ~stage_flush[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_valid <= '0;
            trk_waddr <= '0;
        end else if (stage_ena[2]) begin
            if (xflush) begin
                trk_valid <= '0;
                trk_waddr <= '0;
            end else begin
                trk_valid <= {trk_valid[LD_DEPTH-2:0],
                              (d_advance ? d_load_valid : {ISSUE{1'b0}})};
                trk_waddr <= {trk_waddr[LD_DEPTH-2:0], d_load_waddr};
            end
        end
    end

    // Divider counter. The done flag lets E advance for one cycle while
    // e_div is still high, so a back-to-back divide restarts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (except) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (div_stall) begin
            if (cnt == CW'(DIV_CYC-1)) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (stage_ena[2]) begin
            done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (except && longest_stall) state_d = HOLD;
            HOLD:    if (!longest_stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (NSTAGE=5, ISSUE=2, DIV_CYC=4).
// Each stimulus cycle pushes its expected outputs; a negedge monitor pops
// and compares them against the DUT.

module tb_hazard_ctrl;

    localparam int NSTAGE  = 5;
    localparam int ISSUE   = 2;
    localparam int DIV_CYC = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_stall, d_stall;
    logic [2*ISSUE-1:0]  d_src_valid;
    logic [10*ISSUE-1:0] d_src;
    logic [ISSUE-1:0]    d_load_valid;
    logic [5*ISSUE-1:0]  d_load_waddr;
    logic                d_branch_taken, e_div, except;
    logic [NSTAGE-1:0]   stage_ena, stage_flush;
    logic                longest_stall, lwstall, div_stall, except_pending;

    hazard_ctrl #(.NSTAGE(NSTAGE), .ISSUE(ISSUE), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
        .d_src_valid(d_src_valid), .d_src(d_src),
        .d_load_valid(d_load_valid), .d_load_waddr(d_load_waddr),
        .d_branch_taken(d_branch_taken), .e_div(e_div), .except(except),
        .stage_ena(stage_ena), .stage_flush(stage_flush),
        .longest_stall(longest_stall), .lwstall(lwstall),
        .div_stall(div_stall), .except_pending(except_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [NSTAGE-1:0] ena;
        logic [NSTAGE-1:0] flush;
        logic              ls, lw, ds, ep;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs from the scenario-level facts of one cycle.
    function automatic exp_t mk(string tag, bit lw, bit ls, bit ds, bit xf, bit ep, bit br);
        exp_t e;
        e.tag   = tag;
        e.ena   = {~ls | (ds & xf), ~ls, ~ls, ~(lw | ls), ~(lw | ls)};
        e.flush = {1'b0, xf, xf, xf | br, 1'b0};
        e.ls    = ls;
        e.lw    = lw;
        e.ds    = ds;
        e.ep    = ep;
        return e;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ":ena"},   32'(stage_ena),      32'(e.ena));
            chk({e.tag, ":flush"}, 32'(stage_flush),    32'(e.flush));
            chk({e.tag, ":ls"},    32'(longest_stall),  32'(e.ls));
            chk({e.tag, ":lw"},    32'(lwstall),        32'(e.lw));
            chk({e.tag, ":ds"},    32'(div_stall),      32'(e.ds));
            chk({e.tag, ":ep"},    32'(except_pending), 32'(e.ep));
        end
    end

    task automatic tick(input string tag, input bit lw, input bit ls, input bit ds,
                        input bit xf, input bit ep, input bit br);
        sb.push_back(mk(tag, lw, ls, ds, xf, ep, br));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_stall        = 1'b0;
        d_stall        = 1'b0;
        d_src_valid    = '0;
        d_src          = '0;
        d_load_valid   = '0;
        d_load_waddr   = '0;
        d_branch_taken = 1'b0;
        e_div          = 1'b0;
        except         = 1'b0;
    endtask

    task automatic set_src(input int j, input logic [4:0] r);
        d_src_valid[j]  = 1'b1;
        d_src[5*j +: 5] = r;
    endtask

    task automatic load_use(input string tag, input int ll, input logic [4:0] w, input int rj);
        idle_in();
        d_load_valid[ll]       = 1'b1;
        d_load_waddr[5*ll +: 5] = w;
        tick({tag, "_ld"}, 0, 0, 0, 0, 0, 0);
        idle_in();
        set_src(rj, w);
        set_src(rj ^ 1, 5'd20);
        tick({tag, "_u1"}, 1, 0, 0, 0, 0, 0);
        tick({tag, "_u2"}, 1, 0, 0, 0, 0, 0);
        tick({tag, "_u3"}, 0, 0, 0, 0, 0, 0);
        idle_in();
        tick({tag, "_post"}, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        @(posedge clk);
        #1;
        tick("rst0", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick("idle", 0, 0, 0, 0, 0, 0);

        // Load-use across lanes and slots
        load_use("lu00", 0, 5'd3, 0);
        load_use("lu01", 0, 5'd7, 3);
        load_use("lu10", 1, 5'd9, 1);

        // Load to $0 never stalls a reader of $0
        idle_in();
        d_load_valid[0] = 1'b1;
        d_load_waddr[4:0] = 5'd0;
        tick("z_ld", 0, 0, 0, 0, 0, 0);
        idle_in();
        set_src(0, 5'd0);
        set_src(2, 5'd0);
        tick("z_use", 0, 0, 0, 0, 0, 0);
        idle_in();
        tick("z_post", 0, 0, 0, 0, 0, 0);

        // A taken branch flushes D, so its load never enters the tracker
        d_load_valid[0] = 1'b1;
        d_load_waddr[4:0] = 5'd4;
        d_branch_taken = 1'b1;
        tick("br", 0, 0, 0, 0, 0, 1);
        idle_in();
        set_src(0, 5'd4);
        tick("br_use", 0, 0, 0, 0, 0, 0);
        idle_in();
        tick("br_post", 0, 0, 0, 0, 0, 0);

        // Divider: two back-to-back divides of DIV_CYC cycles each
        e_div = 1'b1;
        repeat (DIV_CYC) tick("div1", 0, 1, 1, 0, 0, 0);
        tick("div1_done", 0, 0, 0, 0, 0, 0);
        repeat (DIV_CYC) tick("div2", 0, 1, 1, 0, 0, 0);
        tick("div2_done", 0, 0, 0, 0, 0, 0);
        e_div = 1'b0;
        tick("div_off", 0, 0, 0, 0, 0, 0);

        // Exception during a data memory stall, tracker cleared on release
        d_load_valid[0] = 1'b1;
        d_load_waddr[4:0] = 5'd6;
        tick("xs_pre", 0, 0, 0, 0, 0, 0);
        idle_in();
        d_stall = 1'b1;
        except  = 1'b1;
        tick("xs0", 0, 1, 0, 1, 0, 0);
        except = 1'b0;
        tick("xs1", 0, 1, 0, 1, 1, 0);
        except = 1'b1;
        tick("xs2", 0, 1, 0, 1, 1, 0);
        except  = 1'b0;
        d_stall = 1'b0;
        tick("xs_rel", 0, 0, 0, 1, 1, 0);
        set_src(0, 5'd6);
        tick("xs_trk", 0, 0, 0, 0, 0, 0);
        idle_in();
        tick("xs_post", 0, 0, 0, 0, 0, 0);

        // Exception during a divide: W released, counter cleared
        e_div = 1'b1;
        tick("xd0", 0, 1, 1, 0, 0, 0);
        except = 1'b1;
        tick("xd1", 0, 1, 1, 1, 0, 0);
        except = 1'b0;
        e_div  = 1'b0;
        tick("xd2", 0, 0, 0, 1, 1, 0);
        e_div = 1'b1;
        repeat (DIV_CYC) tick("xd_div", 0, 1, 1, 0, 0, 0);
        tick("xd_done", 0, 0, 0, 0, 0, 0);
        e_div = 1'b0;
        tick("xd_post", 0, 0, 0, 0, 0, 0);

        // Reset while holding an exception
        d_stall = 1'b1;
        except  = 1'b1;
        tick("rh0", 0, 1, 0, 1, 0, 0);
        except = 1'b0;
        tick("rh1", 0, 1, 0, 1, 1, 0);
        rst = 1'b1;
        tick("rh_rst", 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        tick("rh2", 0, 1, 0, 0, 0, 0);
        d_stall = 1'b0;
        tick("rh3", 0, 0, 0, 0, 0, 0);

        // Reset mid-divide restarts the full count
        e_div = 1'b1;
        tick("rd0", 0, 1, 1, 0, 0, 0);
        tick("rd1", 0, 1, 1, 0, 0, 0);
        rst = 1'b1;
        tick("rd_rst", 0, 1, 1, 0, 0, 0);
        rst = 1'b0;
        repeat (DIV_CYC) tick("rd_div", 0, 1, 1, 0, 0, 0);
        tick("rd_done", 0, 0, 0, 0, 0, 0);
        e_div = 1'b0;
        tick("rd_post", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
